// File: rtl/pong_core.sv
`default_nettype none
// ============================================================================
// Module   : pong_core
// Purpose  : Pong game engine. Divides the system clock down to a game tick
//            and runs an IDLE/SERVE/PLAY/OVER machine. Each tick it moves the
//            ball and both paddles, resolves wall and paddle collisions and
//            keeps both scores. It also supplies every coordinate the VGA
//            renderer needs.
// Ports    : clk, reset (async, active-high), start (pulse),
//            btn_l_up/btn_l_dn, btn_r_up/btn_r_dn (paddle buttons),
//            ai_ctrl_r (right-paddle AI select),
//            tick (one-clk game tick), ball_x/ball_y, paddle_l_y/paddle_r_y,
//            paddle_l_x/paddle_r_x (constant), score_l/score_r, state, winner
// Options  : `define PONG_AI_PADDLE_EN lets ai_ctrl_r=1 hand the right paddle
//            to a ball-tracking AI. When the macro is not defined, ai_ctrl_r
//            is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module pong_core #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int WALL_W      = 14,
    parameter int BALL_W      = 32,
    parameter int PAD_W       = 20,
    parameter int PAD_LEN     = 150,
    parameter int BALL_SPEED  = 4,
    parameter int PAD_SPEED   = 4,
    parameter int TICK_DIV    = 2097152,
    parameter int SERVE_DELAY = 50,
    parameter int WIN_SCORE   = 7,
    parameter int SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               btn_l_up,
    input  logic               btn_l_dn,
    input  logic               btn_r_up,
    input  logic               btn_r_dn,
    input  logic               ai_ctrl_r,
    output logic               tick,
    output logic [9:0]         ball_x,
    output logic [8:0]         ball_y,
    output logic [8:0]         paddle_l_y,
    output logic [8:0]         paddle_r_y,
    output logic [9:0]         paddle_l_x,
    output logic [9:0]         paddle_r_x,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [1:0]         state,
    output logic               winner
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_SRV_W  = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SERVE = 2'd1;
    localparam logic [1:0] c_ST_PLAY  = 2'd2;
    localparam logic [1:0] c_ST_OVER  = 2'd3;

    localparam logic [9:0] c_BALL_X0 = 10'((SCREEN_W - BALL_W) / 2);
    localparam logic [8:0] c_BALL_Y0 = 9'((SCREEN_H - BALL_W) / 2);
    localparam logic [8:0] c_PAD_Y0  = 9'((SCREEN_H - PAD_LEN) / 2);
    localparam logic [8:0] c_PAD_MIN = 9'(WALL_W);
    localparam logic [8:0] c_PAD_MAX = 9'(SCREEN_H - WALL_W - PAD_LEN);
    // Step limits are pre-subtracted so the clamp tests never under/overflow.
    localparam logic [8:0] c_PAD_UP_LIM = 9'(WALL_W + PAD_SPEED);
    localparam logic [8:0] c_PAD_DN_LIM = 9'(SCREEN_H - WALL_W - PAD_LEN - PAD_SPEED);

    localparam logic signed [10:0] c_BSPD     = 11'(BALL_SPEED);
    localparam logic signed [10:0] c_BY_MAX   = 11'(SCREEN_H - WALL_W - BALL_W);
    localparam logic signed [10:0] c_BY_MIN   = 11'(WALL_W);
    localparam logic signed [10:0] c_BX_MAX   = 11'(SCREEN_W - WALL_W - PAD_W - BALL_W);
    localparam logic signed [10:0] c_BX_MIN   = 11'(WALL_W + PAD_W);
    localparam logic signed [10:0] c_PLEN     = 11'(PAD_LEN);
    localparam logic signed [10:0] c_BW       = 11'(BALL_W);
    localparam logic [9:0]         c_BX_RFACE = 10'(SCREEN_W - WALL_W - PAD_W - BALL_W);
    localparam logic [9:0]         c_BX_LFACE = 10'(WALL_W + PAD_W);
    localparam logic [SCORE_W-1:0] c_WIN      = SCORE_W'(WIN_SCORE);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                r_start_pend;
    logic [1:0]          r_state;
    logic [c_SRV_W-1:0]  r_srv_cnt;
    logic [9:0]          r_ball_x;
    logic [8:0]          r_ball_y;
    logic                r_dir_x;     // 1 = moving right
    logic                r_dir_y;     // 1 = moving down
    logic [8:0]          r_pad_l;
    logic [8:0]          r_pad_r;
    logic [SCORE_W-1:0]  r_score_l;
    logic [SCORE_W-1:0]  r_score_r;
    logic                r_winner;

    logic                w_tick;
    logic                w_start_pend;
    logic [1:0]          w_state_nxt;
    logic [c_SRV_W-1:0]  w_srv_cnt_nxt;
    logic [9:0]          w_ball_x_nxt;
    logic [8:0]          w_ball_y_nxt;
    logic                w_dir_x_nxt;
    logic                w_dir_y_nxt;
    logic [8:0]          w_pad_l_nxt;
    logic [8:0]          w_pad_r_nxt;
    logic [SCORE_W-1:0]  w_score_l_nxt;
    logic [SCORE_W-1:0]  w_score_r_nxt;
    logic                w_winner_nxt;

    function automatic logic [8:0] f_pad_move(input logic [8:0] y,
                                              input logic up, input logic dn);
        f_pad_move = y;
        if (up && !dn) begin
            f_pad_move = (y < c_PAD_UP_LIM) ? c_PAD_MIN : y - 9'(PAD_SPEED);
        end else if (dn && !up) begin
            f_pad_move = (y > c_PAD_DN_LIM) ? c_PAD_MAX : y + 9'(PAD_SPEED);
        end
    endfunction

    // ------------------------------------------------------------------
    // Game tick and start request
    // ------------------------------------------------------------------
    assign w_tick       = (r_tick_cnt == c_TICK_W'(TICK_DIV - 1));
    // A start arriving in the tick cycle itself is honoured by that tick.
    assign w_start_pend = r_start_pend | start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt   <= '0;
            r_start_pend <= 1'b0;
        end else begin
            r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + c_TICK_W'(1);
            r_start_pend <= w_tick ? 1'b0 : w_start_pend;
        end
    end

    // ------------------------------------------------------------------
    // Right paddle command source
    // ------------------------------------------------------------------
    logic w_r_up;
    logic w_r_dn;
`ifdef PONG_AI_PADDLE_EN
    logic [10:0] w_ball_c;
    logic [10:0] w_pad_c;
    assign w_ball_c = {2'b00, r_ball_y} + 11'(BALL_W / 2);
    assign w_pad_c  = {2'b00, r_pad_r}  + 11'(PAD_LEN / 2);
    // Dead-band of +/-PAD_SPEED stops the paddle dithering around the ball.
    assign w_r_up = ai_ctrl_r ? (w_ball_c + 11'(PAD_SPEED) < w_pad_c) : btn_r_up;
    assign w_r_dn = ai_ctrl_r ? (w_ball_c > w_pad_c + 11'(PAD_SPEED)) : btn_r_dn;
`else
    logic w_unused_ai;
    assign w_unused_ai = ai_ctrl_r;
    assign w_r_up      = btn_r_up;
    assign w_r_dn      = btn_r_dn;
`endif

    // ------------------------------------------------------------------
    // Ball trajectory candidate (only committed in PLAY)
    // ------------------------------------------------------------------
    logic signed [10:0] w_nx;
    logic signed [10:0] w_ny;
    logic signed [10:0] w_ny_c;
    logic               w_dir_y_c;
    logic               w_edge_r;
    logic               w_edge_l;
    logic               w_hit_r;
    logic               w_hit_l;

    always_comb begin
        w_nx      = r_dir_x ? $signed({1'b0, r_ball_x}) + c_BSPD
                            : $signed({1'b0, r_ball_x}) - c_BSPD;
        w_ny      = r_dir_y ? $signed({2'b00, r_ball_y}) + c_BSPD
                            : $signed({2'b00, r_ball_y}) - c_BSPD;
        w_ny_c    = w_ny;
        w_dir_y_c = r_dir_y;
        if (r_dir_y) begin
            if (w_ny >= c_BY_MAX) begin
                w_ny_c    = c_BY_MAX;
                w_dir_y_c = 1'b0;
            end
        end else if (w_ny <= c_BY_MIN) begin
            w_ny_c    = c_BY_MIN;
            w_dir_y_c = 1'b1;
        end
        w_edge_r = r_dir_x  && (w_nx >= c_BX_MAX);
        w_edge_l = !r_dir_x && (w_nx <= c_BX_MIN);
        // Overlap uses the wall-corrected ny and the pre-tick paddle position.
        w_hit_r  = (w_ny_c < $signed({2'b00, r_pad_r}) + c_PLEN) &&
                   (w_ny_c + c_BW > $signed({2'b00, r_pad_r}));
        w_hit_l  = (w_ny_c < $signed({2'b00, r_pad_l}) + c_PLEN) &&
                   (w_ny_c + c_BW > $signed({2'b00, r_pad_l}));
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_srv_cnt <= '0;
            r_ball_x  <= c_BALL_X0;
            r_ball_y  <= c_BALL_Y0;
            r_dir_x   <= 1'b1;
            r_dir_y   <= 1'b1;
            r_pad_l   <= c_PAD_Y0;
            r_pad_r   <= c_PAD_Y0;
            r_score_l <= '0;
            r_score_r <= '0;
            r_winner  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_srv_cnt <= w_srv_cnt_nxt;
            r_ball_x  <= w_ball_x_nxt;
            r_ball_y  <= w_ball_y_nxt;
            r_dir_x   <= w_dir_x_nxt;
            r_dir_y   <= w_dir_y_nxt;
            r_pad_l   <= w_pad_l_nxt;
            r_pad_r   <= w_pad_r_nxt;
            r_score_l <= w_score_l_nxt;
            r_score_r <= w_score_r_nxt;
            r_winner  <= w_winner_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_srv_cnt_nxt = r_srv_cnt;
        w_ball_x_nxt  = r_ball_x;
        w_ball_y_nxt  = r_ball_y;
        w_dir_x_nxt   = r_dir_x;
        w_dir_y_nxt   = r_dir_y;
        w_pad_l_nxt   = r_pad_l;
        w_pad_r_nxt   = r_pad_r;
        w_score_l_nxt = r_score_l;
        w_score_r_nxt = r_score_r;
        w_winner_nxt  = r_winner;
        if (w_tick) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start_pend) begin
                        w_state_nxt   = c_ST_SERVE;
                        w_srv_cnt_nxt = '0;
                        w_score_l_nxt = '0;
                        w_score_r_nxt = '0;
                    end
                end
                c_ST_SERVE: begin
                    w_pad_l_nxt = f_pad_move(r_pad_l, btn_l_up, btn_l_dn);
                    w_pad_r_nxt = f_pad_move(r_pad_r, w_r_up, w_r_dn);
                    if (r_srv_cnt == c_SRV_W'(SERVE_DELAY - 1)) begin
                        w_state_nxt = c_ST_PLAY;
                    end else begin
                        w_srv_cnt_nxt = r_srv_cnt + c_SRV_W'(1);
                    end
                end
                c_ST_PLAY: begin
                    w_pad_l_nxt  = f_pad_move(r_pad_l, btn_l_up, btn_l_dn);
                    w_pad_r_nxt  = f_pad_move(r_pad_r, w_r_up, w_r_dn);
                    w_ball_x_nxt = w_nx[9:0];
                    w_ball_y_nxt = w_ny_c[8:0];
                    w_dir_y_nxt  = w_dir_y_c;
                    if ((w_edge_r && w_hit_r) || (w_edge_l && w_hit_l)) begin
                        w_ball_x_nxt = w_edge_r ? c_BX_RFACE : c_BX_LFACE;
                        w_dir_x_nxt  = !r_dir_x;
                    end else if (w_edge_r || w_edge_l) begin
                        // Point scored; the serve heads toward whoever conceded.
                        w_ball_x_nxt  = c_BALL_X0;
                        w_ball_y_nxt  = c_BALL_Y0;
                        w_dir_x_nxt   = w_edge_r;
                        w_srv_cnt_nxt = '0;
                        w_state_nxt   = c_ST_SERVE;
                        if (w_edge_r) begin
                            w_score_l_nxt = r_score_l + SCORE_W'(1);
                            if (w_score_l_nxt == c_WIN) begin
                                w_state_nxt  = c_ST_OVER;
                                w_winner_nxt = 1'b0;
                            end
                        end else begin
                            w_score_r_nxt = r_score_r + SCORE_W'(1);
                            if (w_score_r_nxt == c_WIN) begin
                                w_state_nxt  = c_ST_OVER;
                                w_winner_nxt = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (w_start_pend) begin
                        w_state_nxt   = c_ST_SERVE;
                        w_srv_cnt_nxt = '0;
                        w_score_l_nxt = '0;
                        w_score_r_nxt = '0;
                        w_ball_x_nxt  = c_BALL_X0;
                        w_ball_y_nxt  = c_BALL_Y0;
                        w_dir_x_nxt   = 1'b1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        tick       = w_tick;
        ball_x     = r_ball_x;
        ball_y     = r_ball_y;
        paddle_l_y = r_pad_l;
        paddle_r_y = r_pad_r;
        paddle_l_x = 10'(WALL_W);
        paddle_r_x = 10'(SCREEN_W - WALL_W - PAD_W);
        score_l    = r_score_l;
        score_r    = r_score_r;
        state      = r_state;
        winner     = r_winner;
    end

endmodule
`default_nettype wire
